stc_desc_gen: RTL
=================

STC_DESC_GEN -- requirements
Module: stc_desc_gen

Interface
REQ-001 SHALL have parameter M, 16, rows per tile.
REQ-002 SHALL have parameter N_PE, 4, PE count; power of two, 2 <= N_PE <= M.
REQ-003 SHALL have parameters DW_MEM 512, DW_ROWIDX 4 and DW_ELEIDX 8: descriptor width, row-index width and element-index width.
REQ-004 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-006 SHALL have port in_valid, input, 1, row record valid.
REQ-007 SHALL have port in_ready, output, 1, block accepts a row record.
REQ-008 SHALL have port in_nnz, input, DW_ELEIDX, nonzero count of current tile row.
REQ-009 SHALL have port in_row_id, input, DW_ROWIDX, destination output row of current tile row.
REQ-010 SHALL have port cu_idle, input, 1, compute unit can accept a new descriptor.
REQ-011 SHALL have port write_en, output, 1, one-cycle descriptor strobe to compute unit.
REQ-012 SHALL have port cu_input, output, DW_MEM, packed descriptor.
REQ-013 SHALL have port ovf, output, 1, total nnz of held tile exceeded 2^DW_ELEIDX-1.

Function
REQ-014 SHALL implement states COLLECT, PARTITION, SEND; reset state COLLECT.
REQ-015 COLLECT: in_ready=1; on in_valid&in_ready accept row r (r=0..M-1 in order): row2row[r]=in_row_id, row_ptrs[r+1]=row_ptrs[r]+in_nnz mod 2^DW_ELEIDX; row_ptrs[0]=0.
REQ-016 Accepting row M-1 SHALL move to PARTITION next cycle; in_ready=0 outside COLLECT.
REQ-017 ovf SHALL set when the 9-bit running sum exceeds 255, hold until next tile's row 0 is accepted.
REQ-018 PARTITION: boundary b[0]=0; scan r=1..M-1, one row per cycle (M-1 cycles), j starting at 1.
REQ-019 target_j=(total*j)>>log2(N_PE), total=row_ptrs[M], computed at full width (no truncation).
REQ-020 At scan row r with j<N_PE: if row_ptrs[r]>=target_j or (M-r)==(N_PE-j), then b[j]=r, j++.
REQ-021 Partition SHALL guarantee strictly increasing boundaries, each PE >= 1 row; b[N_PE]=M encoded as 0 (mod M).
REQ-022 After scanning r=M-1 SHALL enter SEND.
REQ-023 SEND: in first cycle with cu_idle=1 assert write_en for exactly one cycle, return to COLLECT next cycle.
REQ-024 cu_input layout: row_ptrs[i] at bits i*DW_ELEIDX, i=0..M; row2row[i] at (M+1)*DW_ELEIDX+i*DW_ROWIDX; b[j] at (M+1)*DW_ELEIDX+M*DW_ROWIDX+j*DW_ROWIDX, j=0..N_PE; remaining bits zero.
REQ-025 cu_input SHALL be registered and change only when write_en asserts; stable while next tile collects.
REQ-026 Latency: acceptance of row M-1 at cycle t gives write_en earliest at t+M (cu_idle held 1).
REQ-027 cu_idle low in SEND SHALL stall indefinitely with no strobe and in_ready=0.
REQ-028 in_valid in PARTITION/SEND SHALL be ignored (no acceptance).

Reset
REQ-029 reset SHALL asynchronously clear state to COLLECT, row counter, j, all row_ptrs/row2row/boundaries, cu_input=0, write_en=0, ovf=0.
REQ-030 in_ready SHALL be 0 while reset asserted, 1 in the first cycle after deassertion.
REQ-031 Reset mid-tile or mid-SEND SHALL discard the partial tile; no write_en issued for it.

Structure
REQ-032 Shared package stc_pkg SHALL hold M, N_PE, DW_* constants, descriptor field offsets and state enumeration, shared with the compute unit.
REQ-033 Partition scan SHALL be sub-module stc_wkld_part (inputs row_ptrs, total; outputs boundaries, done).

Verification
REQ-034 All 16 rows nnz=1, row_id=r, cu_idle=1 -> row_ptrs 0..16, b = {0,4,8,12,0}, write_en 16 cycles after last row, ovf=0.
REQ-035 Row0 nnz=16, others 0 -> row_ptrs[1..16]=16, b = {0,1,2,3,0}.
REQ-036 Only row15 nnz=8 -> b = {0,13,14,15,0} (forced-boundary rule).
REQ-037 All rows nnz=20 -> total 320 wraps, ovf=1 at write_en; next tile all nnz=1 clears ovf on its row 0.
REQ-038 cu_idle=0 for 10 cycles in SEND -> no write_en, in_ready=0; cu_idle rise -> single-cycle write_en.
REQ-039 Reset pulse after 7 rows accepted -> outputs zero, next full tile produces correct descriptor from its own 16 rows.

Source files
------------

// File: rtl/stc_pkg.sv
// Shared constants, descriptor field offsets and FSM states for the sparse
// tile descriptor generator and the compute unit that consumes its output.
package stc_pkg;

  localparam int STC_M         = 16;  // rows per tile
  localparam int STC_N_PE      = 4;   // processing elements
  localparam int STC_DW_MEM    = 512; // descriptor width
  localparam int STC_DW_ROWIDX = 4;   // row index width
  localparam int STC_DW_ELEIDX = 8;   // element index width

  localparam int STC_LOG2_N_PE = $clog2(STC_N_PE);

  // Descriptor layout: row pointers, then row remap, then PE boundaries.
  localparam int STC_RP_OFF    = 0;
  localparam int STC_R2R_OFF   = (STC_M + 1) * STC_DW_ELEIDX;
  localparam int STC_BND_OFF   = STC_R2R_OFF + STC_M * STC_DW_ROWIDX;
  localparam int STC_DESC_USED = STC_BND_OFF + (STC_N_PE + 1) * STC_DW_ROWIDX;

  typedef enum logic [1:0] {
    ST_COLLECT   = 2'd0,
    ST_PARTITION = 2'd1,
    ST_SEND      = 2'd2
  } stc_state_e;

endpackage

// File: rtl/stc_wkld_part.sv
// Workload partitioner: scans one tile row per cycle and places N_PE-1
// interior boundaries so every PE gets a roughly equal nonzero share and
// at least one row.
module stc_wkld_part
  import stc_pkg::*;
#(
  parameter int M         = STC_M,
  parameter int N_PE      = STC_N_PE,
  parameter int DW_ROWIDX = STC_DW_ROWIDX,
  parameter int DW_ELEIDX = STC_DW_ELEIDX
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic [DW_ELEIDX-1:0] row_ptrs [0:M],
  input  logic [DW_ELEIDX-1:0] total,
  output logic [DW_ROWIDX-1:0] boundaries [0:N_PE],
  output logic                 done
);

  localparam int RW   = $clog2(M);
  localparam int JW   = $clog2(N_PE) + 1;
  localparam int PW   = DW_ELEIDX + JW;
  localparam int LG_N = $clog2(N_PE);

  logic [RW-1:0]        r_reg;
  logic [JW-1:0]        j_reg;
  logic [DW_ROWIDX-1:0] bnd_reg [1:N_PE-1];

  logic [PW-1:0] prod;
  logic [PW-1:0] target;
  logic [PW-1:0] ptr_ext;
  logic          j_open;
  logic          forced;
  logic          hit;

  // Target share for boundary j and the place/force decision at row r.
  always_comb begin
    prod    = PW'(total) * PW'(j_reg);
    target  = prod >> LG_N;
    ptr_ext = PW'(row_ptrs[r_reg]);
    j_open  = (int'(j_reg) < N_PE);
    // Force a boundary when the remaining rows exactly match remaining PEs.
    forced  = ((M - int'(r_reg)) == (N_PE - int'(j_reg)));
    hit     = j_open && ((ptr_ext >= target) || forced);
    done    = run && (r_reg == RW'(M - 1));
  end

  // Scan counters and boundary registers; counters rearm whenever idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_reg <= RW'(1);
      j_reg <= JW'(1);
      for (int i = 1; i < N_PE; i++) bnd_reg[i] <= '0;
    end else if (run) begin
      if (hit) begin
        bnd_reg[j_reg] <= DW_ROWIDX'(r_reg);
        j_reg          <= j_reg + JW'(1);
      end
      if (done) begin
        r_reg <= RW'(1);
        j_reg <= JW'(1);
      end else begin
        r_reg <= r_reg + RW'(1);
      end
    end else begin
      r_reg <= RW'(1);
      j_reg <= JW'(1);
    end
  end

  // First boundary is always row 0 and the last wraps M to 0.
  always_comb begin
    boundaries[0]    = '0;
    boundaries[N_PE] = DW_ROWIDX'(M % M);
    for (int i = 1; i < N_PE; i++) boundaries[i] = bnd_reg[i];
  end

endmodule

// File: rtl/stc_desc_gen.sv
// Sparse tile descriptor generator: collects M row records, partitions the
// tile across N_PE compute elements and hands a packed descriptor to the
// compute unit with a one-cycle strobe.
module stc_desc_gen
  import stc_pkg::*;
#(
  parameter int M         = STC_M,
  parameter int N_PE      = STC_N_PE,
  parameter int DW_MEM    = STC_DW_MEM,
  parameter int DW_ROWIDX = STC_DW_ROWIDX,
  parameter int DW_ELEIDX = STC_DW_ELEIDX
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DW_ELEIDX-1:0] in_nnz,
  input  logic [DW_ROWIDX-1:0] in_row_id,
  input  logic                 cu_idle,
  output logic                 write_en,
  output logic [DW_MEM-1:0]    cu_input,
  output logic                 ovf
);

  localparam int CW      = $clog2(M);
  localparam int R2R_OFF = (M + 1) * DW_ELEIDX;
  localparam int BND_OFF = R2R_OFF + M * DW_ROWIDX;

  stc_state_e state_reg, state_next;

  logic [CW-1:0]        row_cnt_reg;
  logic [DW_ELEIDX-1:0] row_ptrs_reg [0:M];
  logic [DW_ROWIDX-1:0] row2row_reg  [0:M-1];
  logic                 ovf_reg;
  logic                 write_en_reg;
  logic [DW_MEM-1:0]    cu_input_reg;

  logic                 collect_c;
  logic                 accept;
  logic                 last_row;
  logic                 send_fire;
  logic                 part_done;
  logic [DW_ELEIDX:0]   sum9;
  logic [DW_MEM-1:0]    desc_next;
  logic [DW_ROWIDX-1:0] boundaries [0:N_PE];

  assign accept   = in_valid && collect_c;
  assign last_row = (row_cnt_reg == CW'(M - 1));
  // The extra bit of the running sum is the overflow carry.
  assign sum9     = {1'b0, row_ptrs_reg[row_cnt_reg]} + {1'b0, in_nnz};

  stc_wkld_part #(
    .M         (M),
    .N_PE      (N_PE),
    .DW_ROWIDX (DW_ROWIDX),
    .DW_ELEIDX (DW_ELEIDX)
  ) u_part (
    .clk        (clk),
    .reset      (reset),
    .run        (state_reg == ST_PARTITION),
    .row_ptrs   (row_ptrs_reg),
    .total      (row_ptrs_reg[M]),
    .boundaries (boundaries),
    .done       (part_done)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= ST_COLLECT;
    else       state_reg <= state_next;
  end

  // Next-state logic and handshake decode.
  always_comb begin
    state_next = state_reg;
    collect_c  = 1'b0;
    send_fire  = 1'b0;
    case (state_reg)
      ST_COLLECT: begin
        collect_c = 1'b1;
        if (in_valid && last_row) state_next = ST_PARTITION;
      end
      ST_PARTITION: begin
        if (part_done) state_next = ST_SEND;
      end
      ST_SEND: begin
        if (cu_idle) begin
          send_fire  = 1'b1;
          state_next = ST_COLLECT;
        end
      end
      default: state_next = ST_COLLECT;
    endcase
  end

  // Row capture: prefix-sum pointers, row remap and sticky overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_cnt_reg <= '0;
      ovf_reg     <= 1'b0;
      for (int i = 0; i <= M; i++) row_ptrs_reg[i] <= '0;
      for (int i = 0; i < M; i++)  row2row_reg[i]  <= '0;
    end else if (accept) begin
      for (int i = 0; i < M; i++) begin
        if (row_cnt_reg == CW'(i)) begin
          row_ptrs_reg[i+1] <= sum9[DW_ELEIDX-1:0];
          row2row_reg[i]    <= in_row_id;
        end
      end
      row_cnt_reg <= last_row ? '0 : row_cnt_reg + CW'(1);
      // Row 0 of a new tile starts a fresh overflow window.
      ovf_reg     <= ((row_cnt_reg == '0) ? 1'b0 : ovf_reg) | sum9[DW_ELEIDX];
    end
  end

  // Pack the descriptor fields; unused upper bits stay zero.
  always_comb begin
    desc_next = '0;
    for (int i = 0; i <= M; i++)
      desc_next[i*DW_ELEIDX +: DW_ELEIDX] = row_ptrs_reg[i];
    for (int i = 0; i < M; i++)
      desc_next[R2R_OFF + i*DW_ROWIDX +: DW_ROWIDX] = row2row_reg[i];
    for (int j = 0; j <= N_PE; j++)
      desc_next[BND_OFF + j*DW_ROWIDX +: DW_ROWIDX] = boundaries[j];
  end

  // Descriptor output register and strobe; the descriptor only moves with the strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_en_reg <= 1'b0;
      cu_input_reg <= '0;
    end else begin
      write_en_reg <= send_fire;
      if (send_fire) cu_input_reg <= desc_next;
    end
  end

  assign in_ready = collect_c && !reset;
  assign write_en = write_en_reg;
  assign cu_input = cu_input_reg;
  assign ovf      = ovf_reg;

endmodule
